regfile_core: RTL and testbench



---
 rtl/regfile_core.sv | 154 +++++++++++++++
 tb/tb_regfile_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_core.sv
// -----------------------------------------------------------------------------
// regfile_core
//
// Architectural register file with one write port, one reserve port and two
// registered read ports. Reads return the register contents as they stand after
// the current edge's write, so a same-cycle write to the read address is
// bypassed straight to the read result. A per-register pending bit is set by a
// reserve (issue) and cleared by the matching write (writeback). This lets the
// issue logic see read-after-write hazards while writes are still in flight.
//
// Optional feature (compile-time macro REGFILE_ZERO_REG_EN):
//   defined   - register 0 reads as zero. Writes and reserves to it are ignored.
//   undefined - register 0 is an ordinary register.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   reset        synchronous active-high reset, highest priority
//   rd0_addr     read port 0 address
//   rd0_enable   read port 0 request; data/pending hold when low
//   rd0_data     read port 0 data (registered)
//   rd0_pending  read port 0 target pending flag (registered)
//   rd1_addr     read port 1 address
//   rd1_enable   read port 1 request
//   rd1_data     read port 1 data (registered)
//   rd1_pending  read port 1 pending flag (registered)
//   wr_addr      write address
//   wr_enable    write strobe; also clears pending[wr_addr]
//   wr_data      write data
//   rsv_addr     destination register being reserved by issue
//   rsv_enable   reserve strobe; sets pending[rsv_addr]
//   any_pending  OR of all pending bits (registered)
// -----------------------------------------------------------------------------
module regfile_core #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] rd0_addr,
    input  logic                 rd0_enable,
    output logic [DATA_BITS-1:0] rd0_data,
    output logic                 rd0_pending,
    input  logic [ADDR_BITS-1:0] rd1_addr,
    input  logic                 rd1_enable,
    output logic [DATA_BITS-1:0] rd1_data,
    output logic                 rd1_pending,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 wr_enable,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rsv_addr,
    input  logic                 rsv_enable,
    output logic                 any_pending
);

    localparam int REG_COUNT = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] regs_q [REG_COUNT];
    logic [DATA_BITS-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] pend_q;
    logic [REG_COUNT-1:0] pend_d;

    logic [DATA_BITS-1:0] rd0_data_q, rd0_data_d;
    logic [DATA_BITS-1:0] rd1_data_q, rd1_data_d;
    logic                 rd0_pend_q, rd0_pend_d;
    logic                 rd1_pend_q, rd1_pend_d;
    logic                 any_pend_q, any_pend_d;

    logic                 wr_ok_s;
    logic                 rsv_ok_s;

    // Qualify write/reserve strobes; register 0 may be hardwired to zero.
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        wr_ok_s  = wr_enable  && (wr_addr  != {ADDR_BITS{1'b0}});
        rsv_ok_s = rsv_enable && (rsv_addr != {ADDR_BITS{1'b0}});
`else
        wr_ok_s  = wr_enable;
        rsv_ok_s = rsv_enable;
`endif
    end

    // Post-edge register and pending state (write first, then reserve so the
    // newer producer wins on a same-address collision).
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok_s) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        if (rsv_ok_s) begin
            pend_d[rsv_addr] = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // Read ports sample the post-update state, which implements the bypass.
    always_comb begin
        rd0_data_d = rd0_data_q;
        rd0_pend_d = rd0_pend_q;
        rd1_data_d = rd1_data_q;
        rd1_pend_d = rd1_pend_q;
        if (rd0_enable) begin
            rd0_data_d = regs_d[rd0_addr];
            rd0_pend_d = pend_d[rd0_addr];
        end else begin
            rd0_data_d = rd0_data_q;
            rd0_pend_d = rd0_pend_q;
        end
        if (rd1_enable) begin
            rd1_data_d = regs_d[rd1_addr];
            rd1_pend_d = pend_d[rd1_addr];
        end else begin
            rd1_data_d = rd1_data_q;
            rd1_pend_d = rd1_pend_q;
        end
        any_pend_d = |pend_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= {DATA_BITS{1'b0}};
            end
            pend_q     <= {REG_COUNT{1'b0}};
            rd0_data_q <= {DATA_BITS{1'b0}};
            rd1_data_q <= {DATA_BITS{1'b0}};
            rd0_pend_q <= 1'b0;
            rd1_pend_q <= 1'b0;
            any_pend_q <= 1'b0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q     <= pend_d;
            rd0_data_q <= rd0_data_d;
            rd1_data_q <= rd1_data_d;
            rd0_pend_q <= rd0_pend_d;
            rd1_pend_q <= rd1_pend_d;
            any_pend_q <= any_pend_d;
        end
    end

    assign rd0_data    = rd0_data_q;
    assign rd0_pending = rd0_pend_q;
    assign rd1_data    = rd1_data_q;
    assign rd1_pending = rd1_pend_q;
    assign any_pending = any_pend_q;

endmodule

// File: tb/tb_regfile_core.sv
// -----------------------------------------------------------------------------
// tb_regfile_core
//
// Directed testbench for regfile_core. An array-based reference model of the
// architectural state predicts every output after each clock. It is compared
// every cycle. Literal expectations at the key steps pin the model itself.
// -----------------------------------------------------------------------------
module tb_regfile_core;

    localparam int AB = 4;
    localparam int DB = 8;
    localparam int N  = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AB-1:0] rd0_addr, rd1_addr, wr_addr, rsv_addr;
    logic          rd0_enable, rd1_enable, wr_enable, rsv_enable;
    logic [DB-1:0] wr_data;
    logic [DB-1:0] rd0_data, rd1_data;
    logic          rd0_pending, rd1_pending, any_pending;

    int passed = 0;
    int total  = 0;

    // reference model state
    int m_reg  [N];
    bit m_pend [N];
    int e_rd0_data, e_rd1_data;
    bit e_rd0_pend, e_rd1_pend, e_any;

    regfile_core #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset),
        .rd0_addr(rd0_addr), .rd0_enable(rd0_enable),
        .rd0_data(rd0_data), .rd0_pending(rd0_pending),
        .rd1_addr(rd1_addr), .rd1_enable(rd1_enable),
        .rd1_data(rd1_data), .rd1_pending(rd1_pending),
        .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
        .rsv_addr(rsv_addr), .rsv_enable(rsv_enable),
        .any_pending(any_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance the model by one edge using the current inputs.
    task automatic model_step();
        int wa, ra;
        wa = int'(wr_addr);
        ra = int'(rsv_addr);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_reg[i] = 0;
                m_pend[i] = 1'b0;
            end
            e_rd0_data = 0; e_rd1_data = 0;
            e_rd0_pend = 1'b0; e_rd1_pend = 1'b0; e_any = 1'b0;
        end else begin
            if (wr_enable && !(ZERO_EN && wa == 0)) begin
                m_reg[wa] = int'(wr_data);
                m_pend[wa] = 1'b0;
            end
            if (rsv_enable && !(ZERO_EN && ra == 0)) m_pend[ra] = 1'b1;
            if (rd0_enable) begin
                e_rd0_data = m_reg[rd0_addr];
                e_rd0_pend = m_pend[rd0_addr];
            end
            if (rd1_enable) begin
                e_rd1_data = m_reg[rd1_addr];
                e_rd1_pend = m_pend[rd1_addr];
            end
            e_any = 1'b0;
            for (int i = 0; i < N; i++) e_any = e_any | m_pend[i];
        end
    endtask

    // One clock: update model, take the edge, compare all outputs after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("rd0_data",    int'(rd0_data),    e_rd0_data);
        check("rd0_pending", int'(rd0_pending), int'(e_rd0_pend));
        check("rd1_data",    int'(rd1_data),    e_rd1_data);
        check("rd1_pending", int'(rd1_pending), int'(e_rd1_pend));
        check("any_pending", int'(any_pending), int'(e_any));
    endtask

    task automatic idle();
        reset = 1'b0;
        rd0_enable = 1'b0; rd1_enable = 1'b0;
        wr_enable = 1'b0; rsv_enable = 1'b0;
        rd0_addr = 4'd0; rd1_addr = 4'd0; wr_addr = 4'd0; rsv_addr = 4'd0;
        wr_data = 8'h00;
    endtask

    initial begin
        int exp0;
        idle();
        // 1. reset for two cycles, then read r3 on both ports
        reset = 1'b1;
        tick(); tick();
        idle();
        rd0_enable = 1'b1; rd0_addr = 4'd3;
        rd1_enable = 1'b1; rd1_addr = 4'd3;
        tick();
        check("t1_rd0_data", int'(rd0_data), 0);
        check("t1_rd1_data", int'(rd1_data), 0);
        check("t1_any", int'(any_pending), 0);

        // 2. write then read; then bypass on rd1
        idle(); wr_enable = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
        tick();
        idle(); rd0_enable = 1'b1; rd0_addr = 4'd5;
        tick();
        check("t2_rd0_data", int'(rd0_data), 'hA5);
        idle(); wr_enable = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C;
        rd1_enable = 1'b1; rd1_addr = 4'd5;
        tick();
        check("t2_bypass", int'(rd1_data), 'h3C);
        check("t2_rd0_hold", int'(rd0_data), 'hA5);

        // 3. reserve r7, read it, then write it while reading
        idle(); rsv_enable = 1'b1; rsv_addr = 4'd7;
        tick();
        idle(); rd0_enable = 1'b1; rd0_addr = 4'd7;
        tick();
        check("t3_pend", int'(rd0_pending), 1);
        check("t3_any", int'(any_pending), 1);
        idle(); wr_enable = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
        rd0_enable = 1'b1; rd0_addr = 4'd7;
        tick();
        check("t3_data", int'(rd0_data), 'h11);
        check("t3_pend_clr", int'(rd0_pending), 0);
        check("t3_any_clr", int'(any_pending), 0);

        // 4. same-cycle reserve+write to r2, then hold while disabled
        idle(); rsv_enable = 1'b1; rsv_addr = 4'd2;
        wr_enable = 1'b1; wr_addr = 4'd2; wr_data = 8'h44;
        tick();
        idle(); rd0_enable = 1'b1; rd0_addr = 4'd2;
        tick();
        check("t4_data", int'(rd0_data), 'h44);
        check("t4_pend", int'(rd0_pending), 1);
        for (int k = 0; k < 3; k++) begin
            idle(); wr_enable = 1'b1; wr_addr = 4'd2; wr_data = 8'h99;
            rd0_addr = 4'd2;
            tick();
            check("t4_hold", int'(rd0_data), 'h44);
        end
        check("t4_hold_pend", int'(rd0_pending), 1);
        check("t4_any", int'(any_pending), 0);

        // 5. state then reset colliding with a write; everything reads zero
        idle(); wr_enable = 1'b1; wr_addr = 4'd9; wr_data = 8'h77;
        rsv_enable = 1'b1; rsv_addr = 4'd4;
        tick();
        check("t5_any_pre", int'(any_pending), 1);
        idle(); reset = 1'b1; wr_enable = 1'b1; wr_addr = 4'd9; wr_data = 8'hFF;
        tick();
        idle(); rd0_enable = 1'b1; rd0_addr = 4'd9;
        rd1_enable = 1'b1; rd1_addr = 4'd4;
        tick();
        check("t5_r9", int'(rd0_data), 0);
        check("t5_r4_pend", int'(rd1_pending), 0);
        check("t5_any", int'(any_pending), 0);

        // 6. register 0 write with same-cycle reads on both ports
        exp0 = ZERO_EN ? 0 : 'h5A;
        idle(); wr_enable = 1'b1; wr_addr = 4'd0; wr_data = 8'h5A;
        rd0_enable = 1'b1; rd1_enable = 1'b1;
        tick();
        check("t6_rd0_c1", int'(rd0_data), exp0);
        check("t6_rd1_c1", int'(rd1_data), exp0);
        idle(); rd0_enable = 1'b1; rd1_enable = 1'b1;
        tick();
        check("t6_rd0_c2", int'(rd0_data), exp0);
        check("t6_rd1_c2", int'(rd1_data), exp0);

        // 7. sweep all addresses with distinct data, top address reserved
        for (int a = 0; a < N; a++) begin
            idle(); wr_enable = 1'b1; wr_addr = AB'(a);
            wr_data = DB'((a * 37) ^ 8'hC3);
            rd1_enable = 1'b1; rd1_addr = AB'(a);
            tick();
        end
        idle(); rsv_enable = 1'b1; rsv_addr = 4'd15;
        tick();
        for (int a = 0; a < N; a++) begin
            idle(); rd0_enable = 1'b1; rd0_addr = AB'(a);
            rd1_enable = 1'b1; rd1_addr = AB'(N - 1 - a);
            tick();
        end
        check("t7_r0_via_rd1", int'(rd1_data), ZERO_EN ? 0 : 'hC3);
        check("t7_r15_pend", int'(rd0_pending), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
